inst_decode: RTL
================

Name: inst_decode

Overview:
- Decode stage directly downstream of instruction fetch.
- Consumes the fetched instruction word and its word PC.
- Reads the register file asynchronously, resolves branches and jumps in the same cycle, and drives the redirect/stall signals back to fetch.
- Registers the decoded operation into an ID/EX pipeline register for the execute stage.
- Provides a RAW interlock against all in-flight writers. There is no forwarding.

Parameters:
- RESET_PC, 30'h0, word PC loaded into ex_pc on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- inst  in  32  instruction from fetch; 0 is treated as NOP.
- pc  in  30  word address [31:2] of inst.
- stall  out  1  interlock request to fetch (combinational).
- jump  out  1  redirect fetch (combinational).
- jump_pc  out  30  redirect target, word address (combinational).
- rs_addr  out  5  regfile read port A = inst[25:21].
- rt_addr  out  5  regfile read port B = inst[20:16].
- rs_data  in  32  async read data A.
- rt_data  in  32  async read data B.
- mem_we  in  1  MEM stage will write the regfile.
- mem_dest  in  5  MEM stage destination.
- wb_we  in  1  WB stage writes this cycle.
- wb_dest  in  5  WB stage destination.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 PASSB.
- ex_a  out  32  ALU operand A.
- ex_b  out  32  ALU operand B.
- ex_wr_en  out  1  write result to regfile.
- ex_wr_addr  out  5  destination register.
- ex_mem_rd  out  1  LW.
- ex_mem_wr  out  1  SW.
- ex_store_data  out  32  rt_data for SW.
- ex_pc  out  30  PC of the instruction in ID/EX.
- ex_illegal  out  1  unsupported opcode/funct seen.

Behaviour:
- Reset (rst=0, async): every ex_* output is 0, except ex_pc = RESET_PC. Combinational outputs then evaluate with ex_wr_en=0.
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, JR.
  - ADDIU, SLTIU, SLTI, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, J, JAL.
- Operand rules:
  - ADDIU/SLTI/SLTIU/LW/SW use the sign-extended imm16.
  - ANDI/ORI/XORI use the zero-extended imm16.
  - LUI: ex_b = {imm16, 16'h0}, op PASSB.
  - Shifts: ex_a = shamt zero-extended, ex_b = rt_data.
  - LW/SW use op ADD.
- Destination:
  - rd for R-type, rt for I-type, 31 for JAL.
  - ex_wr_en is forced 0 when the destination is 0; SW, branches, J and JR also have ex_wr_en=0.
- Source-use rules:
  - R-type ALU ops and JR read rs.
  - Shifts read rt only.
  - I-type reads rs; SW, BEQ and BNE also read rt.
  - J, JAL and LUI read nothing.
- Hazard: stall=1 when a source register that is used and nonzero equals any of:
  - ex_wr_addr with ex_wr_en=1;
  - mem_dest with mem_we=1;
  - wb_dest with wb_we=1.
- On stall:
  - jump=1 and jump_pc=pc, so fetch re-fetches the same word next cycle.
  - ID/EX loads a bubble: ex_valid=0, ex_wr_en=0, ex_mem_rd=0, ex_mem_wr=0, ex_illegal=0.
  - Branch evaluation is suppressed.
- Control transfer (no stall; no delay slot; zero penalty):
  - BEQ/BNE: compare rs_data and rt_data. If taken, jump=1 and jump_pc = pc + 1 + sext(imm16), with 30-bit wrap.
  - J/JAL: jump_pc = {pc[31:28], inst[25:0]}.
  - JR: jump_pc = rs_data[31:2]; the low bits are ignored.
  - JAL: writes link {pc+1, 2'b00} to r31 (op PASSB, ex_b = link).
- Non-taken branches and J/JR enter ID/EX with ex_valid=1 and ex_wr_en=0.
- Otherwise jump=0 and jump_pc=pc+1 (don't-care).
- Illegal opcode/funct: ID/EX loads a bubble with ex_illegal=1 for one cycle, and ex_pc = pc.
- inst=0 (SLL $0): ex_valid=1, ex_wr_en=0.
- ex_pc tracks pc every non-reset cycle, including bubbles.
- Latency: one cycle from inst/pc to the ID/EX outputs; the redirect path is zero-cycle combinational.

Test Plan:
- Reset: rst=0 mid-operation with ex_wr_en=1 → all ex_* outputs 0 immediately, ex_pc=0; after release, inst=0 → ex_valid=1, ex_wr_en=0.
- ADDIU $2,$1,-1 (inst=32'h2422FFFF), rs_data=5 → next cycle: ex_alu_op=0, ex_a=5, ex_b=32'hFFFFFFFF, ex_wr_addr=2, ex_wr_en=1.
- Load-use: LW $3,0($1) then ADDU $4,$3,$3 → second cycle: stall=1, jump=1, jump_pc=pc; then a bubble in ID/EX. With mem_we=1/mem_dest=3 the stall continues; it clears once wb_we drops.
- BEQ at pc=30'h10, imm=16'hFFFE, rs_data=rt_data=7 → jump=1, jump_pc=30'h0F. With rt_data=8 → jump=0.
- JAL at pc=30'h20 (target field 26'h100) → jump_pc=30'h100; the next cycle has ex_wr_addr=31 and ex_b=32'h84.
- inst=32'hFC000000 → ex_illegal=1 and ex_valid=0 for exactly one cycle.

Source files
------------

// File: rtl/inst_decode.sv
// Decode stage: register read, same-cycle branch/jump resolution, RAW interlock
// against in-flight writers, and the ID/EX pipeline register.
module inst_decode #(
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [29:0] pc,
    output logic        stall,
    output logic        jump,
    output logic [29:0] jump_pc,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mem_we,
    input  logic [4:0]  mem_dest,
    input  logic        wb_we,
    input  logic [4:0]  wb_dest,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_op,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic        ex_wr_en,
    output logic [4:0]  ex_wr_addr,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic [31:0] ex_store_data,
    output logic [29:0] ex_pc,
    output logic        ex_illegal
);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_SLL   = 4'd8;
    localparam logic [3:0] ALU_SRL   = 4'd9;
    localparam logic [3:0] ALU_SRA   = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] shamt_zext;
    logic [29:0] pc_plus1;

    assign opcode     = inst[31:26];
    assign funct      = inst[5:0];
    assign rs_addr    = inst[25:21];
    assign rt_addr    = inst[20:16];
    assign rd         = inst[15:11];
    assign imm_sext   = {{16{inst[15]}}, inst[15:0]};
    assign imm_zext   = {16'h0, inst[15:0]};
    assign shamt_zext = {27'h0, inst[10:6]};
    assign pc_plus1   = pc + 30'd1;

    logic        legal;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  dest;
    logic        wr;
    logic        use_rs;
    logic        use_rt;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;
    logic        is_jr;

    always_comb begin
        legal  = 1'b1;
        alu_op = ALU_ADD;
        op_a   = rs_data;
        op_b   = rt_data;
        dest   = rt_addr;
        wr     = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        is_beq = 1'b0;
        is_bne = 1'b0;
        is_j   = 1'b0;
        is_jr  = 1'b0;
        case (opcode)
            6'h00: begin
                dest   = rd;
                wr     = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
                case (funct)
                    6'h21: alu_op = ALU_ADD;
                    6'h23: alu_op = ALU_SUB;
                    6'h24: alu_op = ALU_AND;
                    6'h25: alu_op = ALU_OR;
                    6'h26: alu_op = ALU_XOR;
                    6'h27: alu_op = ALU_NOR;
                    6'h2A: alu_op = ALU_SLT;
                    6'h2B: alu_op = ALU_SLTU;
                    6'h00, 6'h02, 6'h03: begin
                        // shifts take shamt as A and never look at rs
                        use_rs = 1'b0;
                        op_a   = shamt_zext;
                        alu_op = (funct == 6'h00) ? ALU_SLL :
                                 (funct == 6'h02) ? ALU_SRL : ALU_SRA;
                    end
                    6'h08: begin
                        is_jr  = 1'b1;
                        wr     = 1'b0;
                        use_rt = 1'b0;
                    end
                    default: begin
                        legal  = 1'b0;
                        wr     = 1'b0;
                        use_rs = 1'b0;
                        use_rt = 1'b0;
                    end
                endcase
            end
            6'h02: is_j = 1'b1;
            6'h03: begin
                is_j   = 1'b1;
                dest   = 5'd31;
                wr     = 1'b1;
                alu_op = ALU_PASSB;
                op_b   = {pc_plus1, 2'b00};
            end
            6'h04: begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            6'h05: begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            6'h09: begin op_b = imm_sext; wr = 1'b1; use_rs = 1'b1; end
            6'h0A: begin op_b = imm_sext; wr = 1'b1; use_rs = 1'b1; alu_op = ALU_SLT; end
            6'h0B: begin op_b = imm_sext; wr = 1'b1; use_rs = 1'b1; alu_op = ALU_SLTU; end
            6'h0C: begin op_b = imm_zext; wr = 1'b1; use_rs = 1'b1; alu_op = ALU_AND; end
            6'h0D: begin op_b = imm_zext; wr = 1'b1; use_rs = 1'b1; alu_op = ALU_OR; end
            6'h0E: begin op_b = imm_zext; wr = 1'b1; use_rs = 1'b1; alu_op = ALU_XOR; end
            6'h0F: begin op_b = {inst[15:0], 16'h0}; wr = 1'b1; alu_op = ALU_PASSB; end
            6'h23: begin op_b = imm_sext; wr = 1'b1; use_rs = 1'b1; mem_rd = 1'b1; end
            6'h2B: begin
                op_b   = imm_sext;
                use_rs = 1'b1;
                use_rt = 1'b1;
                mem_wr = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (dest == 5'd0)
            wr = 1'b0;
    end

    logic hit_rs;
    logic hit_rt;

    assign hit_rs = use_rs && (rs_addr != 5'd0) &&
                    ((ex_wr_en && ex_wr_addr == rs_addr) ||
                     (mem_we && mem_dest == rs_addr) ||
                     (wb_we && wb_dest == rs_addr));
    assign hit_rt = use_rt && (rt_addr != 5'd0) &&
                    ((ex_wr_en && ex_wr_addr == rt_addr) ||
                     (mem_we && mem_dest == rt_addr) ||
                     (wb_we && wb_dest == rt_addr));
    assign stall  = hit_rs || hit_rt;

    logic        regs_eq;
    logic [29:0] br_target;

    assign regs_eq   = (rs_data == rt_data);
    assign br_target = pc_plus1 + imm_sext[29:0];

    // a stall redirects to pc itself so fetch replays the word
    always_comb begin
        jump    = 1'b0;
        jump_pc = pc_plus1;
        if (stall) begin
            jump    = 1'b1;
            jump_pc = pc;
        end else if (is_j) begin
            jump    = 1'b1;
            jump_pc = {pc[29:26], inst[25:0]};
        end else if (is_jr) begin
            jump    = 1'b1;
            jump_pc = rs_data[31:2];
        end else if ((is_beq && regs_eq) || (is_bne && !regs_eq)) begin
            jump    = 1'b1;
            jump_pc = br_target;
        end
    end

    logic issue;
    assign issue = !stall && legal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= 4'd0;
            ex_a          <= 32'h0;
            ex_b          <= 32'h0;
            ex_wr_en      <= 1'b0;
            ex_wr_addr    <= 5'd0;
            ex_mem_rd     <= 1'b0;
            ex_mem_wr     <= 1'b0;
            ex_store_data <= 32'h0;
            ex_pc         <= RESET_PC;
            ex_illegal    <= 1'b0;
        end else begin
            ex_valid      <= issue;
            ex_alu_op     <= alu_op;
            ex_a          <= op_a;
            ex_b          <= op_b;
            ex_wr_en      <= issue && wr;
            ex_wr_addr    <= dest;
            ex_mem_rd     <= issue && mem_rd;
            ex_mem_wr     <= issue && mem_wr;
            ex_store_data <= rt_data;
            ex_pc         <= pc;
            ex_illegal    <= !stall && !legal;
        end
    end

endmodule
